// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared pipeline types for the rv32i core
package rv32i_types;

   // IF/ID pipeline register as seen by decode
   typedef struct packed {
      logic [31:0] inst_s;
      logic [31:0] pc_s;
      logic [31:0] pc_next_s;
      logic        valid_s;
      logic [63:0] order_s;
   } if_id_stage_reg_t;

   // One fetched instruction together with its address
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   localparam logic [3:0] IMEM_FULL_MASK = 4'hF;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-2 circular FIFO with registered storage and clear
module fetch_fifo #(
   parameter int  DEPTH   = 4,
   parameter type entry_t = logic [63:0]
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         push,
   input  entry_t                       wdata,
   input  logic                         pop,
   output entry_t                       rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          pop_ok;

   // The caller guarantees push is only raised when there is room
   // (or a pop happens in the same cycle); pop is ignored when empty.
   assign pop_ok = pop && !empty;
   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign rdata  = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of 2
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage has no reset; contents are only observed through count
   always_ff @(posedge clk) begin
      if (push && !rst && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - prefetching fetch stage; optional same-cycle bypass via IF_PREFETCH_BYPASS_EN
module if_prefetch
   import rv32i_types::*;
#(
   parameter int          DEPTH        = 4,
   parameter int          MAX_INFLIGHT = 2,
   parameter logic [31:0] RESET_PC     = 32'h1eceb000
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   output logic [3:0]       imem_rmask,
   input  logic             imem_resp,
   input  logic [31:0]      imem_rdata,
   output if_id_stage_reg_t if_id_reg,
   input  logic             id_ready,
   input  logic             flush,
   input  logic [31:0]      target_pc
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(MAX_INFLIGHT+1);

   // live_cnt counts outstanding requests whose words will be kept;
   // discard counts outstanding requests whose words will be dropped.
   // Their sum is the total number of reads the memory still owes us.
   logic [31:0]   fetch_pc;
   logic [IW-1:0] live_cnt;
   logic [IW-1:0] discard;
   logic [IW-1:0] inflight;
   logic [63:0]   order;

   logic [31:0]   infl32, live32, cnt32;
   logic [31:0]   pend_pc;
   logic          issue;
   logic          resp_live;
   logic          resp_dec;
   logic          live_dec;
   logic          head_valid;
   logic          byp_valid;
   logic          out_valid;
   logic          consume;

   fetch_entry_t  q_rdata;
   fetch_entry_t  q_wdata;
   fetch_entry_t  out_entry;
   logic [CW-1:0] q_count;
   logic          q_full;
   logic          q_empty;
   logic          q_push;
   logic          q_pop;

   assign inflight = live_cnt + discard;
   assign infl32   = 32'(inflight);
   assign live32   = 32'(live_cnt);
   assign cnt32    = 32'(q_count);

   // Live requests are sequential and end just below fetch_pc, so the
   // oldest one (the one answering now) sits live_cnt words back.
   assign pend_pc  = fetch_pc - (live32 << 2);

   // Issue control: every live request must have a reserved queue slot
   always_comb begin
      issue = !rst && !flush
              && (infl32 < 32'(MAX_INFLIGHT))
              && ((cnt32 + infl32) < 32'(DEPTH))
              && ((live32 + cnt32) < 32'(DEPTH));
      imem_req   = issue;
      imem_addr  = fetch_pc;
      imem_rmask = issue ? IMEM_FULL_MASK : 4'h0;
   end

   // Response classification and output selection (queue head or bypass)
   always_comb begin
      resp_live  = imem_resp && (discard == '0) && !flush && !rst;
      resp_dec   = imem_resp && (inflight != '0);
      live_dec   = imem_resp && (discard == '0) && (live_cnt != '0);
      head_valid = !q_empty && !flush && !rst;
`ifdef IF_PREFETCH_BYPASS_EN
      byp_valid  = resp_live && q_empty;
`else
      byp_valid  = 1'b0;
`endif
      out_valid  = head_valid || byp_valid;
      consume    = out_valid && id_ready;

      q_wdata.pc   = pend_pc;
      q_wdata.inst = imem_rdata;
      out_entry    = head_valid ? q_rdata : q_wdata;

      q_pop  = head_valid && id_ready;
      q_push = resp_live && !(byp_valid && id_ready) && (!q_full || q_pop);
   end

   // Decode-facing register image; all zero whenever nothing is valid
   always_comb begin
      if_id_reg = '0;
      if (out_valid) begin
         if_id_reg.inst_s    = out_entry.inst;
         if_id_reg.pc_s      = out_entry.pc;
         if_id_reg.pc_next_s = out_entry.pc + 32'd4;
         if_id_reg.valid_s   = 1'b1;
         if_id_reg.order_s   = order;
      end
   end

   // Fetch pc, request accounting and instruction order counter.
   // On reset or redirect every outstanding read becomes stale, except a
   // response arriving that very cycle, which is dropped on the spot.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         live_cnt <= '0;
         discard  <= inflight - IW'(resp_dec);
         order    <= '0;
      end else if (flush) begin
         fetch_pc <= target_pc;
         live_cnt <= '0;
         discard  <= inflight - IW'(resp_dec);
      end else begin
         if (issue) fetch_pc <= fetch_pc + 32'd4;
         live_cnt <= live_cnt + IW'(issue) - IW'(live_dec);
         if (imem_resp && (discard != '0)) discard <= discard - 1'b1;
         if (consume) order <= order + 64'd1;
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (fetch_entry_t)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .push  (q_push),
      .wdata (q_wdata),
      .pop   (q_pop),
      .rdata (q_rdata),
      .count (q_count),
      .full  (q_full),
      .empty (q_empty)
   );

endmodule
